// File: rtl/sensor_condition_sync_if.sv
// Route-controller <-> sensor condition synchroniser handshake.
//   arm       : one-cycle request, latches cond_mask/cond_mode
//   cancel    : abort a pending wait
//   cond_mask : sensor set the condition looks at
//   cond_mode : 0=ANY, 1=NONE, 2=TIMER, 3=ALL
//   y         : one-cycle "condition satisfied" pulse
//   busy      : wait pending or firing
// master = route controller, slave = synchroniser.
interface sensor_condition_sync_if #(
  parameter int NUM_SENSORS = 6
);
  logic                   arm;
  logic                   cancel;
  logic [NUM_SENSORS-1:0] cond_mask;
  logic [1:0]             cond_mode;
  logic                   y;
  logic                   busy;

  modport master (output arm, cancel, cond_mask, cond_mode, input y, busy);
  modport slave  (input arm, cancel, cond_mask, cond_mode, output y, busy);
endinterface

// File: rtl/sensor_condition_sync.sv
// Track-sensor condition synchroniser.
// Each raw sensor passes through a 2-flop synchroniser and a debouncer; the
// timer flag is synchronised only. On arm, a mask+mode condition is latched
// and the block waits until it holds, then emits a one-cycle y pulse.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   sensor_in   : raw asynchronous sensor levels (bit i = sensor S(i+1))
//   timer_in    : raw asynchronous timer-expired level
//   ctl         : handshake interface (slave side)
//   sensor_db   : debounced sensor levels

// One sensor lane: 2-flop synchroniser followed by a stability counter.
module scsDebounceLane #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rawIn,
  output logic dbOut
);
  logic             sync1, sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      dbOut <= 1'b0;
    end else begin
      sync1 <= rawIn;
      sync2 <= sync1;
      if (sync2 == dbOut) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // Differed for DEBOUNCE_CYCLES consecutive cycles: accept new level.
        dbOut <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module sensor_condition_sync #(
  parameter int NUM_SENSORS     = 6,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SENSORS-1:0] sensor_in,
  input  logic                   timer_in,
  sensor_condition_sync_if.slave ctl,
  output logic [NUM_SENSORS-1:0] sensor_db
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [1:0] MODE_ANY   = 2'd0;
  localparam logic [1:0] MODE_NONE  = 2'd1;
  localparam logic [1:0] MODE_TIMER = 2'd2;
  localparam logic [1:0] MODE_ALL   = 2'd3;

  typedef enum logic [1:0] {IDLE, ARMED, FIRE} state_t;

  state_t                 state;
  logic [NUM_SENSORS-1:0] latMask;
  logic [1:0]             latMode;
  logic                   timerSync1, timerSync;
  logic                   condTrue;

  // Per-sensor lanes; vector ports are split one bit per instance.
  scsDebounceLane #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) uLane [NUM_SENSORS-1:0] (
    .clk  (clk),
    .rst_n(rst_n),
    .rawIn(sensor_in),
    .dbOut(sensor_db)
  );

  // Timer flag is already a clean level; synchronise only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timerSync1 <= 1'b0;
      timerSync  <= 1'b0;
    end else begin
      timerSync1 <= timer_in;
      timerSync  <= timerSync1;
    end
  end

  // Condition from the latched mask/mode; a zero mask makes ANY never true
  // and NONE/ALL trivially true.
  always_comb begin
    condTrue = 1'b0;
    case (latMode)
      MODE_ANY:   condTrue = |(sensor_db & latMask);
      MODE_NONE:  condTrue = ~|(sensor_db & latMask);
      MODE_TIMER: condTrue = timerSync;
      MODE_ALL:   condTrue = &(sensor_db | ~latMask);
      default:    condTrue = 1'b0;
    endcase
  end

  // y/busy are registered alongside the state so they are glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      latMask  <= '0;
      latMode  <= '0;
      ctl.y    <= 1'b0;
      ctl.busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ctl.y <= 1'b0;
          if (ctl.arm && !ctl.cancel) begin
            latMask  <= ctl.cond_mask;
            latMode  <= ctl.cond_mode;
            state    <= ARMED;
            ctl.busy <= 1'b1;
          end else begin
            ctl.busy <= 1'b0;
          end
        end
        ARMED: begin
          // cancel wins over a condition that becomes true the same cycle
          if (ctl.cancel) begin
            state    <= IDLE;
            ctl.busy <= 1'b0;
            ctl.y    <= 1'b0;
          end else if (condTrue) begin
            state    <= FIRE;
            ctl.busy <= 1'b1;
            ctl.y    <= 1'b1;
          end else begin
            ctl.busy <= 1'b1;
            ctl.y    <= 1'b0;
          end
        end
        FIRE: begin
          state    <= IDLE;
          ctl.y    <= 1'b0;
          ctl.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          ctl.y    <= 1'b0;
          ctl.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sensor_condition_sync.sv
module tb_sensor_condition_sync;
  localparam int NS = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS-1:0] sensor_in;
  logic          timer_in;
  logic [NS-1:0] sensor_db;

  int nChecks = 0;
  int nPass   = 0;

  sensor_condition_sync_if #(.NUM_SENSORS(NS)) ctl ();

  sensor_condition_sync #(.NUM_SENSORS(NS), .DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sensor_in(sensor_in),
    .timer_in (timer_in),
    .ctl      (ctl.slave),
    .sensor_db(sensor_db)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic armWith(input logic [NS-1:0] m, input logic [1:0] md);
    ctl.arm = 1'b1; ctl.cond_mask = m; ctl.cond_mode = md;
    tick();
    ctl.arm = 1'b0;
  endtask

  initial begin
    logic sawY;
    rst_n = 1'b0; sensor_in = 6'h3F; timer_in = 1'b1;
    ctl.arm = 1'b0; ctl.cancel = 1'b0; ctl.cond_mask = '0; ctl.cond_mode = 2'd0;

    // Reset with all inputs high
    tick(3);
    chk("rst_y", ctl.y, 0);
    chk("rst_busy", ctl.busy, 0);
    chk("rst_db", sensor_db, 0);
    rst_n = 1'b1;
    tick(5);
    chk("db_lat5", sensor_db, 6'h00);
    tick();
    chk("db_lat6", sensor_db, 6'h3F);
    sensor_in = '0; timer_in = 1'b0;
    tick(8);
    chk("db_clear", sensor_db, 6'h00);

    // Glitch of 3 cycles is filtered
    sensor_in[2] = 1'b1;
    tick(3);
    sensor_in[2] = 1'b0;
    sawY = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sensor_db[2]) sawY = 1'b1;
    end
    chk("glitch_db2", sawY, 0);

    // Stable rise lands exactly 6 cycles later
    sensor_in[2] = 1'b1;
    tick(5);
    chk("rise_db2_5", sensor_db[2], 0);
    tick();
    chk("rise_db2_6", sensor_db[2], 1);
    tick(4);
    sensor_in[2] = 1'b0;
    tick(8);

    // ANY of S1|S6; mask input changed after arm must not matter
    armWith(6'b100001, 2'd0);
    ctl.cond_mask = '0;
    chk("any_busy", ctl.busy, 1);
    tick(3);
    chk("any_wait_y", ctl.y, 0);
    sensor_in[5] = 1'b1;
    tick(6);
    chk("any_db5", sensor_db[5], 1);
    chk("any_y_early", ctl.y, 0);
    tick();
    chk("any_y", ctl.y, 1);
    chk("any_busy_fire", ctl.busy, 1);
    tick();
    chk("any_y_off", ctl.y, 0);
    chk("any_idle", ctl.busy, 0);
    sensor_in[5] = 1'b0;
    tick(8);

    // Zero mask: NONE and ALL fire at t+2
    armWith(6'b0, 2'd1);
    chk("none_t1_y", ctl.y, 0);
    tick();
    chk("none_t2_y", ctl.y, 1);
    tick();
    chk("none_done", ctl.busy, 0);
    armWith(6'b0, 2'd3);
    chk("all_t1_y", ctl.y, 0);
    tick();
    chk("all_t2_y", ctl.y, 1);
    tick();
    // Zero mask ANY never fires
    armWith(6'b0, 2'd0);
    sawY = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (ctl.y) sawY = 1'b1;
    end
    chk("any0_noy", sawY, 0);
    chk("any0_busy", ctl.busy, 1);
    ctl.cancel = 1'b1;
    tick();
    ctl.cancel = 1'b0;
    chk("any0_cancel", ctl.busy, 0);

    // arm together with cancel in IDLE is not accepted
    ctl.arm = 1'b1; ctl.cancel = 1'b1; ctl.cond_mode = 2'd1;
    tick();
    ctl.arm = 1'b0; ctl.cancel = 1'b0;
    chk("armcancel_idle", ctl.busy, 0);

    // Cancel beats timer the cycle timer_sync first reads 1
    armWith(6'b0, 2'd2);
    timer_in = 1'b1;
    tick(2);
    chk("tmr_pending", ctl.busy, 1);
    ctl.cancel = 1'b1;
    tick();
    ctl.cancel = 1'b0;
    chk("tmr_cancel_y", ctl.y, 0);
    chk("tmr_cancel_busy", ctl.busy, 0);
    armWith(6'b0, 2'd2);
    chk("tmr_rearm", ctl.busy, 1);
    tick();
    chk("tmr_fire", ctl.y, 1);
    tick();
    timer_in = 1'b0;
    tick(3);

    // Reset mid-wait while condition becomes true
    armWith(6'b000001, 2'd0);
    sensor_in[0] = 1'b1;
    tick(6);
    chk("midrst_db0", sensor_db[0], 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_y", ctl.y, 0);
    chk("midrst_busy", ctl.busy, 0);
    sawY = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ctl.y || ctl.busy) sawY = 1'b1;
    end
    chk("midrst_idle", sawY, 0);
    sensor_in = '0;
    tick(8);

    // Arm while busy is ignored: latched mask stays S2
    armWith(6'b000010, 2'd0);
    ctl.arm = 1'b1; ctl.cond_mask = 6'b000001;
    tick();
    ctl.arm = 1'b0;
    sensor_in[0] = 1'b1;
    sawY = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ctl.y) sawY = 1'b1;
    end
    chk("busyarm_noy", sawY, 0);
    chk("busyarm_busy", ctl.busy, 1);
    sensor_in[1] = 1'b1;
    tick(6);
    chk("busyarm_y_early", ctl.y, 0);
    tick();
    chk("busyarm_y", ctl.y, 1);
    tick();
    chk("busyarm_idle", ctl.busy, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  // Hard bound on run length
  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/sensor_condition_sync.md
Name: sensor_condition_sync

Overview:
- Parametrised successor to the train-route sensor synchroniser.
- Synchronises and debounces NUM_SENSORS asynchronous track-sensor inputs plus a timer flag.
- On an arm request from the route controller FSM, waits until a programmable condition (any / none / all of a masked sensor set, or the timer) holds, then emits a one-cycle `y` pulse.
- Sits between the raw track sensors and the route controller. Replaces the fixed 16-entry selector decode with a mask+mode condition latched at arm time.

Parameters:
- NUM_SENSORS, 6, number of track sensor inputs (>=1).
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a debounced sensor changes (>=1).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- sensor_in  in  NUM_SENSORS  raw asynchronous sensor levels; bit i = sensor S(i+1).
- timer_in  in  1  asynchronous timer-expired level.
- arm  in  1  one-cycle request; latches cond_mask/cond_mode and starts a wait.
- cancel  in  1  aborts a pending wait.
- cond_mask  in  NUM_SENSORS  sensor set used by the condition.
- cond_mode  in  2  0=ANY of mask, 1=NONE of mask, 2=TIMER, 3=ALL of mask.
- y  out  1  one-cycle pulse: condition satisfied.
- busy  out  1  high while a wait is pending or firing.
- sensor_db  out  NUM_SENSORS  debounced sensor levels.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all sync flops, sensor_db, debounce counters, latched mask/mode cleared to 0;
  - FSM=IDLE; y=0, busy=0.
  - Reset mid-wait aborts with no `y` pulse.
- Synchroniser: each sensor_in bit and timer_in pass through 2 flops. timer_sync = second-stage timer flop (not debounced).
- Debounce, per sensor i:
  - if sync[i]==sensor_db[i]: counter=0;
  - else counter+1; when counter reaches DEBOUNCE_CYCLES-1 and sync still differs, sensor_db[i]<=sync[i] and counter=0.
  - Latency from a stable sensor_in change to sensor_db = 2+DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES sync cycles never reaches sensor_db.
- Condition, combinational from latched mask M / mode and current sensor_db D:
  - ANY: |(D&M)
  - NONE: ~|(D&M)
  - ALL: &(D|~M)
  - TIMER: timer_sync
  - M=0: ANY never true; NONE and ALL true immediately.
- FSM states IDLE, ARMED, FIRE:
  - IDLE: busy=0. arm=1 and cancel=0 -> latch mask/mode, go ARMED. cancel in IDLE ignored.
  - ARMED: busy=1.
    - cancel=1 -> IDLE, no pulse. cancel has priority over a true condition in the same cycle.
    - else condition true -> FIRE.
    - else stay. arm ignored.
  - FIRE: y=1, busy=1 for exactly one cycle, then IDLE. arm in FIRE ignored.
- Timing: arm at cycle t -> ARMED at t+1. First evaluation is in cycle t+1, so the earliest y is cycle t+2.
- Mask/mode changes on inputs after arm have no effect until the next accepted arm.
- y and busy are registered (FSM-state decoded), glitch-free.
- Compatibility mappings:
  - old selector 0 = mask S1|S6, ANY
  - old selector 10 = mask S1..S4, NONE
  - old selectors 2-5 = TIMER

Test Plan:
- Reset: hold rst_n=0 with sensor_in=6'h3F and timer_in=1 for 3 cycles -> y=0, busy=0, sensor_db=0. After release, sensor_db=6'h3F exactly 2+4 cycles later.
- Debounce: DEBOUNCE_CYCLES=4, pulse sensor_in[2] high for 3 cycles -> sensor_db[2] stays 0. Hold high for 10 cycles -> sensor_db[2]=1 at cycle 6 after the rise.
- ANY wait: arm with mask=6'b100001, mode=0, all sensors low. Raise sensor_in[5] -> exactly one y pulse 1 cycle after sensor_db[5] rises, then busy=0.
- NONE/ALL with mask=0: arm with mode=1 at t -> y=1 at t+2. Repeat with mode=3 -> y=1 at t+2. Repeat with mode=0 -> no y for 50 cycles, busy stays 1.
- Cancel priority: armed in TIMER mode, assert cancel in the same cycle timer_sync first reads 1 -> no y, busy=0 next cycle. A new arm is accepted the following cycle.
- Reset mid-wait: armed in ANY mode, pull rst_n low for 1 cycle while the condition becomes true -> no y pulse, FSM=IDLE. An arm while busy=1 is ignored, so the latched mask is unchanged.
